layers_stream: RTL and testbench

//  Parametrised, fully handshaked post-accumulation datapath: pool -> ReLU -> rescale/saturate.

---
 rtl/layers_stream.sv | 167 ++++++++++++++++
 tb/tb_layers_stream.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layers_stream.sv
// Pool -> ReLU -> rescale/saturate stream stage with valid/ready on both sides and an output FIFO.
// Optional build macro LAYERS_STREAM_ROUND_EN: round half up before the rescale shift.
module layers_stream #(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int CFG_ADDR   = 0,
    parameter int DEPTH_NB   = 16,
    parameter int NUM_WIDTH  = 33,
    parameter int IMG_WIDTH  = 16,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CFG_DWIDTH-1:0]           cfg_data,
    input  logic [CFG_AWIDTH-1:0]           cfg_addr,
    input  logic                            cfg_valid,
    input  logic [DEPTH_NB*NUM_WIDTH-1:0]   up_data,
    input  logic                            up_last,
    input  logic                            up_val,
    output logic                            up_rdy,
    output logic [DEPTH_NB*IMG_WIDTH-1:0]   dn_data,
    output logic                            dn_last,
    output logic                            dn_val,
    input  logic                            dn_rdy
);
    localparam int PW = NUM_WIDTH + 8;
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int OW = AW + 3;
    localparam logic [7:0] PW_SH = 8'(PW);
    localparam logic signed [PW:0] MAXV = {{(PW-IMG_WIDTH+2){1'b0}}, {(IMG_WIDTH-1){1'b1}}};
    localparam logic signed [PW:0] MINV = {{(PW-IMG_WIDTH+2){1'b1}}, {(IMG_WIDTH-1){1'b0}}};
`ifdef LAYERS_STREAM_ROUND_EN
    localparam logic signed [PW:0] ONE = {{PW{1'b0}}, 1'b1};
`endif

    logic                          mode_sh_q, bypass_sh_q, mode_q, bypass_q;
    logic [7:0]                    nb_sh_q, shift_sh_q, nb_q, shift_q, cnt_q, p1_shift_q;
    logic                          done_q, done_last_q, p1_val_q, p1_last_q;
    logic [AW-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [AW:0]                   fifo_cnt_q;
    logic [DEPTH_NB*IMG_WIDTH-1:0] mem_q [OUT_DEPTH];
    logic [OUT_DEPTH-1:0]          last_mem_q;
    logic [DEPTH_NB*IMG_WIDTH-1:0] push_data;
    logic                          cfg_wr, first_beat, is_end, accept, close, push, pop;
    logic [7:0]                    nb_eff, nb_m1;
    logic [OW-1:0]                 occ;
    logic                          unused_cfg_bits;

    assign unused_cfg_bits = ^{cfg_data[CFG_DWIDTH-1:26], cfg_data[7:0]};

    // The first beat of a window sees the shadow config, which becomes active on that beat.
    always_comb begin
        cfg_wr     = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_ADDR));
        first_beat = (cnt_q == 8'd0);
        nb_eff     = first_beat ? nb_sh_q : nb_q;
        nb_m1      = (nb_eff == 8'd0) ? 8'd0 : nb_eff - 8'd1;
        is_end     = (cnt_q == nb_m1);
        occ        = OW'(fifo_cnt_q) + OW'(done_q) + OW'(p1_val_q) + OW'(is_end);
        up_rdy     = (occ < OW'(OUT_DEPTH));
        accept     = up_val && up_rdy;
        close      = accept && (is_end || up_last);
        push       = p1_val_q;
        pop        = (fifo_cnt_q != '0) && dn_rdy;
    end

    assign dn_val  = (fifo_cnt_q != '0);
    assign dn_data = mem_q[rd_ptr_q];
    assign dn_last = last_mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sh_q   <= 1'b0;
            bypass_sh_q <= 1'b0;
            nb_sh_q     <= 8'd1;
            shift_sh_q  <= 8'd0;
            mode_q      <= 1'b0;
            bypass_q    <= 1'b0;
            nb_q        <= 8'd0;
            shift_q     <= 8'd0;
            cnt_q       <= 8'd0;
            done_q      <= 1'b0;
            done_last_q <= 1'b0;
            p1_val_q    <= 1'b0;
            p1_last_q   <= 1'b0;
            p1_shift_q  <= 8'd0;
        end else begin
            if (cfg_wr) begin
                mode_sh_q   <= cfg_data[25];
                bypass_sh_q <= cfg_data[24];
                nb_sh_q     <= cfg_data[23:16];
                shift_sh_q  <= cfg_data[15:8];
            end
            if (accept && first_beat) begin
                mode_q   <= mode_sh_q;
                bypass_q <= bypass_sh_q;
                nb_q     <= nb_sh_q;
                shift_q  <= shift_sh_q;
            end
            if (accept) cnt_q <= close ? 8'd0 : cnt_q + 8'd1;
            done_q      <= close;
            done_last_q <= close && up_last;
            p1_val_q    <= done_q;
            p1_last_q   <= done_last_q;
            // Shift travels with the data: the next window may reload shift_q meanwhile.
            if (done_q) p1_shift_q <= shift_q;
        end
    end

    for (genvar gi = 0; gi < DEPTH_NB; gi++) begin : g_ch
        logic signed [PW-1:0]        in_s, acc_q, relu_q;
        logic signed [PW:0]          wide, shf;
        logic signed [IMG_WIDTH-1:0] sat;

        assign in_s = {{8{up_data[gi*NUM_WIDTH+NUM_WIDTH-1]}}, up_data[gi*NUM_WIDTH +: NUM_WIDTH]};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q  <= '0;
                relu_q <= '0;
            end else begin
                if (accept) begin
                    if (first_beat)  acc_q <= in_s;
                    else if (mode_q) acc_q <= acc_q + in_s;
                    else if (in_s > acc_q) acc_q <= in_s;
                end
                if (done_q) relu_q <= (!bypass_q && acc_q[PW-1]) ? '0 : acc_q;
            end
        end

        always_comb begin
            wide = {relu_q[PW-1], relu_q};
`ifdef LAYERS_STREAM_ROUND_EN
            if (p1_shift_q != 8'd0 && p1_shift_q < PW_SH)
                wide = wide + (ONE <<< (p1_shift_q - 8'd1));
`endif
            if (p1_shift_q >= PW_SH) shf = {(PW+1){wide[PW]}};
            else                     shf = wide >>> p1_shift_q;
            if (shf > MAXV)          sat = MAXV[IMG_WIDTH-1:0];
            else if (shf < MINV)     sat = MINV[IMG_WIDTH-1:0];
            else                     sat = shf[IMG_WIDTH-1:0];
        end

        assign push_data[gi*IMG_WIDTH +: IMG_WIDTH] = sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            last_mem_q <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q]      <= push_data;
                last_mem_q[wr_ptr_q] <= p1_last_q;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_layers_stream.sv
// Directed bench for layers_stream: pooling modes, ReLU, rescale/saturate, backpressure, up_last, reset.
module tb_layers_stream;
    localparam int NW = 33;
    localparam int IW = 16;
    localparam int DN = 16;
    localparam int OD = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       cfg_data;
    logic [4:0]        cfg_addr;
    logic              cfg_valid;
    logic [DN*NW-1:0]  up_data;
    logic              up_last, up_val, up_rdy;
    logic [DN*IW-1:0]  dn_data;
    logic              dn_last, dn_val, dn_rdy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layers_stream dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .up_data(up_data), .up_last(up_last), .up_val(up_val), .up_rdy(up_rdy),
        .dn_data(dn_data), .dn_last(dn_last), .dn_val(dn_val), .dn_rdy(dn_rdy)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic cfg_write(input bit mode, input bit bypass, input int nb, input int shift);
        cfg_data        = '0;
        cfg_data[25]    = mode;
        cfg_data[24]    = bypass;
        cfg_data[23:16] = nb[7:0];
        cfg_data[15:8]  = shift[7:0];
        cfg_addr        = '0;
        cfg_valid       = 1'b1;
        @(negedge clk);
        cfg_valid       = 1'b0;
    endtask

    task automatic send_beat(input int c0, input int c1, input bit last);
        bit got = 0;
        up_data       = '0;
        up_data[0+:NW]  = NW'(c0);
        up_data[NW+:NW] = NW'(c1);
        up_last       = last;
        up_val        = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (up_rdy) begin got = 1; break; end
            @(negedge clk);
        end
        if (got) @(negedge clk);
        else check("send_timeout", 0, 1);
        up_val  = 1'b0;
        up_last = 1'b0;
    endtask

    task automatic get_result(output int c0, output int c1, output bit last);
        bit got = 0;
        c0 = 0; c1 = 0; last = 0;
        for (int i = 0; i < 100; i++) begin
            if (dn_val) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) begin
            check("recv_timeout", 0, 1);
        end else begin
            c0     = $signed(dn_data[IW-1:0]);
            c1     = $signed(dn_data[2*IW-1:IW]);
            last   = dn_last;
            dn_rdy = 1'b1;
            @(negedge clk);
            dn_rdy = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r0, r1, n_acc;
        bit rl, rdy_s;
        rst_n = 1'b0; cfg_data = '0; cfg_addr = '0; cfg_valid = 1'b0;
        up_data = '0; up_last = 1'b0; up_val = 1'b0; dn_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dn_val", dn_val, 0);
        check("rst_dn_data_nonzero", (dn_data != '0), 0);
        check("rst_dn_last", dn_last, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_up_rdy", up_rdy, 1);

        // Max pool of 4 beats, latency of three cycles from the closing beat
        cfg_write(0, 0, 4, 0);
        send_beat(5, 1, 0);
        send_beat(-3, 8, 0);
        send_beat(9, -20, 0);
        send_beat(2, 3, 0);
        check("max_lat_c1", dn_val, 0);
        @(negedge clk);
        check("max_lat_c2", dn_val, 0);
        @(negedge clk);
        check("max_lat_c3", dn_val, 1);
        get_result(r0, r1, rl);
        check("max_ch0", r0, 9);
        check("max_ch1", r1, 8);
        check("max_last", rl, 0);
        repeat (4) @(negedge clk);
        check("max_single_result", dn_val, 0);

        // Sum pool with and without ReLU
        cfg_write(1, 0, 2, 0);
        send_beat(-7, 3, 0);
        send_beat(-1, 4, 0);
        get_result(r0, r1, rl);
        check("sum_relu_ch0", r0, 0);
        check("sum_relu_ch1", r1, 7);
        cfg_write(1, 1, 2, 0);
        send_beat(-7, 3, 0);
        send_beat(-1, 4, 0);
        get_result(r0, r1, rl);
        check("sum_bypass_ch0", r0, -8);

        // Saturation
        cfg_write(0, 1, 1, 0);
        send_beat(100000, -5, 0);
        get_result(r0, r1, rl);
        check("sat_pos", r0, 32767);
        check("sat_pass", r1, -5);
        send_beat(-100000, 0, 0);
        get_result(r0, r1, rl);
        check("sat_neg", r0, -32768);

        // Rescale shift with optional rounding
        cfg_write(0, 1, 1, 2);
        send_beat(6, 0, 0);
        get_result(r0, r1, rl);
`ifdef LAYERS_STREAM_ROUND_EN
        check("shift_pos", r0, 2);
`else
        check("shift_pos", r0, 1);
`endif
        send_beat(-6, 0, 0);
        get_result(r0, r1, rl);
`ifdef LAYERS_STREAM_ROUND_EN
        check("shift_neg", r0, -1);
`else
        check("shift_neg", r0, -2);
`endif
        cfg_write(0, 1, 1, 50);
        send_beat(-6, 6, 0);
        get_result(r0, r1, rl);
        check("shift_big_neg", r0, -1);
        check("shift_big_pos", r1, 0);

        // Config written mid-window only applies to the following window
        cfg_write(1, 1, 2, 0);
        send_beat(10, 0, 0);
        cfg_write(0, 1, 3, 0);
        send_beat(20, 0, 0);
        get_result(r0, r1, rl);
        check("cfg_mid_window", r0, 30);
        send_beat(7, 0, 0);
        send_beat(3, 0, 0);
        send_beat(-1, 0, 0);
        get_result(r0, r1, rl);
        check("cfg_next_window", r0, 7);

        // up_last closes a window early; counting restarts afterwards
        cfg_write(1, 1, 4, 0);
        send_beat(3, 0, 0);
        send_beat(4, 0, 1);
        get_result(r0, r1, rl);
        check("last_early_val", r0, 7);
        check("last_early_flag", rl, 1);
        for (int i = 0; i < 4; i++) send_beat(1, 0, 0);
        get_result(r0, r1, rl);
        check("last_restart_val", r0, 4);
        check("last_restart_flag", rl, 0);
        send_beat(5, 0, 1);
        get_result(r0, r1, rl);
        check("last_single_val", r0, 5);
        check("last_single_flag", rl, 1);

        // Backpressure: downstream stalled, ingress must throttle without loss
        cfg_write(0, 1, 1, 0);
        n_acc = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            up_data = '0;
            up_data[0+:NW] = NW'(100 + n_acc);
            up_val = (n_acc < 10);
            rdy_s  = up_rdy;
            @(negedge clk);
            if (rdy_s && up_val) n_acc++;
        end
        up_val = 1'b0;
        check("bp_stalled", (n_acc < 10), 1);
        check("bp_accept_bound", (n_acc >= OD - 1 && n_acc <= OD), 1);
        check("bp_up_rdy_low", up_rdy, 0);
        check("bp_head_held", $signed(dn_data[IW-1:0]), 100);
        for (int k = 0; k < n_acc; k++) begin
            get_result(r0, r1, rl);
            check($sformatf("bp_order_%0d", k), r0, 100 + k);
        end
        for (int k = n_acc; k < 10; k++) begin
            send_beat(100 + k, 0, 0);
            get_result(r0, r1, rl);
            check($sformatf("bp_order_%0d", k), r0, 100 + k);
        end

        // Asynchronous reset with FIFO content and a partial window
        send_beat(55, 0, 0);
        repeat (2) @(negedge clk);
        check("arst_pre_val", dn_val, 1);
        cfg_write(1, 1, 4, 0);
        send_beat(1, 0, 0);
        send_beat(2, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dn_val", dn_val, 0);
        check("arst_dn_data_nonzero", (dn_data != '0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_up_rdy", up_rdy, 1);
        send_beat(9, 0, 0);
        get_result(r0, r1, rl);
        check("arst_first_val", r0, 9);
        check("arst_first_last", rl, 0);
        send_beat(-4, 0, 0);
        get_result(r0, r1, rl);
        check("arst_cfg_default_relu", r0, 0);
        repeat (4) @(negedge clk);
        check("arst_no_stale", dn_val, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
